// File: rtl/display_scan_mux_if.sv
// Bus bundle between a value source and the display scan multiplexer.
// The master side supplies the value and controls; the slave side returns the scan drive.
interface display_scan_mux_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] valor_i;
    logic                  load_i;
    logic                  blank_lz_i;
    logic [3:0]            palabra_o;
    logic [N_DIGITS-1:0]   an_o;
    logic                  pend_o;

    modport master (
        output valor_i,
        output load_i,
        output blank_lz_i,
        input  palabra_o,
        input  an_o,
        input  pend_o
    );

    modport slave (
        input  valor_i,
        input  load_i,
        input  blank_lz_i,
        output palabra_o,
        output an_o,
        output pend_o
    );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed hex scan driver for display7: one nibble per digit slot,
// active-low digit enables, new values committed only at frame boundaries.
module display_scan_mux #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 27000
) (
    input logic              clk,
    input logic              rst_n,
    display_scan_mux_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int DW = 4 * N_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]       presc_q,    presc_d;
    logic [IW-1:0]       idx_q,      idx_d;
    logic [DW-1:0]       pend_reg_q, pend_reg_d;
    logic                pend_q,     pend_d;
    logic [DW-1:0]       disp_q,     disp_d;
    logic [3:0]          palabra_q,  palabra_d;
    logic [N_DIGITS-1:0] an_q,       an_d;

    logic                tick;
    logic                frame_end;
    logic [N_DIGITS-1:0] blank_mask;

    assign tick      = (presc_q == PRESC_LAST);
    assign frame_end = tick && (idx_q == IDX_LAST);

    // Prescaler and digit index
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // A load landing on the frame boundary goes straight to the display and
    // supersedes anything still pending.
    always_comb begin
        pend_reg_d = pend_reg_q;
        pend_d     = pend_q;
        disp_d     = disp_q;
        if (frame_end) begin
            if (bus.load_i) begin
                disp_d = bus.valor_i;
                pend_d = 1'b0;
            end else if (pend_q) begin
                disp_d = pend_reg_q;
                pend_d = 1'b0;
            end
        end else if (bus.load_i) begin
            pend_reg_d = bus.valor_i;
            pend_d     = 1'b1;
        end
    end

    // Digit k is a leading zero when it and every higher nibble are zero;
    // digit 0 always stays lit so a zero value still shows "0".
    always_comb begin
        logic run_zero;
        run_zero   = 1'b1;
        blank_mask = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run_zero      = run_zero && (disp_q[4*k +: 4] == 4'h0);
            blank_mask[k] = bus.blank_lz_i && run_zero && (k != 0);
        end
    end

    always_comb begin
        logic blanked;
        palabra_d = 4'h0;
        an_d      = '1;
        blanked   = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                palabra_d = disp_q[4*k +: 4];
                an_d[k]   = 1'b0;
                blanked   = blank_mask[k];
            end
        end
        if (blanked) begin
            palabra_d = 4'h0;
            an_d      = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_reg_q <= '0;
            pend_q     <= 1'b0;
            disp_q     <= '0;
            palabra_q  <= 4'h0;
            an_q       <= '1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_reg_q <= pend_reg_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            palabra_q  <= palabra_d;
            an_q       <= an_d;
        end
    end

    assign bus.palabra_o = palabra_q;
    assign bus.an_o      = an_q;
    assign bus.pend_o    = pend_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with REFRESH_DIV=4, N_DIGITS=4.
// Cycle c after reset release shows digit ((c-1)/4)%4; commits land on edges 16, 32, 48, ...
module tb_display_scan_mux;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   cyc;

    display_scan_mux_if #(.N_DIGITS(4)) bus ();

    display_scan_mux #(
        .N_DIGITS    (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clk_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst an", 32'(bus.an_o), 32'hF);
        chk("rst pal", 32'(bus.palabra_o), 32'h0);
        chk("rst pend", 32'(bus.pend_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // pal/an hold the expected nibble / enable pattern per digit, digit 0 in bits [3:0]
    task automatic check_frame(input string tag, input int first, input logic [15:0] pal,
                               input logic [15:0] an);
        int d;
        clk_to(first - 1);
        for (int i = 0; i < 16; i++) begin
            step();
            d = ((cyc - 1) / 4) % 4;
            chk($sformatf("%s pal d%0d", tag, d), 32'(bus.palabra_o), 32'(pal[d*4 +: 4]));
            chk($sformatf("%s an d%0d", tag, d), 32'(bus.an_o), 32'(an[d*4 +: 4]));
        end
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        cyc            = 0;
        rst_n          = 1'b1;
        bus.valor_i    = '0;
        bus.load_i     = 1'b0;
        bus.blank_lz_i = 1'b0;

        // Reset behaviour and first edge
        do_reset();
        step();
        chk("first edge an", 32'(bus.an_o), 32'hE);
        chk("first edge pal", 32'(bus.palabra_o), 32'h0);

        // Scan timing: load while idx=2, commit at frame end
        clk_to(9);
        bus.valor_i = 16'h1234;
        bus.load_i  = 1'b1;
        step();
        bus.load_i = 1'b0;
        chk("t2 pend set", 32'(bus.pend_o), 32'h1);
        chk("t2 still blank pal", 32'(bus.palabra_o), 32'h0);
        chk("t2 still old an", 32'(bus.an_o), 32'hB);
        clk_to(15);
        chk("t2 pend held", 32'(bus.pend_o), 32'h1);
        clk_to(16);
        chk("t2 pend clr", 32'(bus.pend_o), 32'h0);
        check_frame("t2", 17, 16'h1234, 16'h7BDE);

        // Leading-zero blanking
        do_reset();
        bus.blank_lz_i = 1'b1;
        step();
        bus.valor_i = 16'h0050;
        bus.load_i  = 1'b1;
        step();
        bus.load_i = 1'b0;
        check_frame("t3a", 17, 16'h0050, 16'hFFDE);
        bus.valor_i = 16'h0000;
        bus.load_i  = 1'b1;
        step();
        bus.load_i = 1'b0;
        check_frame("t3b", 49, 16'h0000, 16'hFFFE);
        bus.blank_lz_i = 1'b0;
        check_frame("t3c", 65, 16'h0000, 16'h7BDE);

        // Load collision on the frame_end cycle
        do_reset();
        clk_to(5);
        bus.valor_i = 16'hAAAA;
        bus.load_i  = 1'b1;
        step();
        bus.load_i = 1'b0;
        chk("t4 pend A", 32'(bus.pend_o), 32'h1);
        clk_to(15);
        bus.valor_i = 16'hBBBB;
        bus.load_i  = 1'b1;
        step();
        bus.load_i = 1'b0;
        chk("t4 pend clr", 32'(bus.pend_o), 32'h0);
        check_frame("t4", 17, 16'hBBBB, 16'h7BDE);

        // Overwrite while pending
        bus.valor_i = 16'h1111;
        bus.load_i  = 1'b1;
        step();
        bus.valor_i = 16'h2222;
        step();
        bus.load_i = 1'b0;
        chk("t5 pend", 32'(bus.pend_o), 32'h1);
        clk_to(47);
        chk("t5 pend held", 32'(bus.pend_o), 32'h1);
        chk("t5 old shown", 32'(bus.palabra_o), 32'hB);
        clk_to(48);
        chk("t5 pend clr", 32'(bus.pend_o), 32'h0);
        check_frame("t5", 49, 16'h2222, 16'h7BDE);

        // Prescaler and wrap across three frames
        do_reset();
        check_frame("t6f0", 1, 16'h0000, 16'h7BDE);
        check_frame("t6f1", 17, 16'h0000, 16'h7BDE);
        check_frame("t6f2", 33, 16'h0000, 16'h7BDE);
        step();
        chk("t6 wrap an", 32'(bus.an_o), 32'hE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
